// File: rtl/btn_tick_gen.sv
`default_nettype none
// ============================================================================
// Module   : btn_tick_gen
// Brief    : Synchronises and debounces a raw push-button and emits one
//            fixed-width tick pulse per accepted press, with optional
//            auto-repeat while the button is held. Drives the clock input
//            of the downstream ripple counter (which advances on the
//            falling edge of tick_out).
// Revision : 1.0 - initial release
// ============================================================================
module btn_tick_gen #(
    parameter int STABLE_CYCLES = 8,
    parameter int PULSE_CYCLES  = 2,
    parameter int HOLD_CYCLES   = 32,
    parameter int REPEAT_CYCLES = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_in,
    input  logic       repeat_en,
    output logic       tick_out,
    output logic       pressed,
    output logic [7:0] tick_count
);

    // Counter width covers the largest count limit; the largest value ever
    // held is (max parameter - 1), so $clog2 of the max parameter suffices.
    localparam int c_MAX_A = (STABLE_CYCLES > HOLD_CYCLES) ? STABLE_CYCLES : HOLD_CYCLES;
    localparam int c_MAX   = (c_MAX_A > REPEAT_CYCLES) ? c_MAX_A : REPEAT_CYCLES;
    localparam int c_CW    = (c_MAX > 1) ? $clog2(c_MAX) : 1;
    localparam int c_PW    = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES + 1) : 1;

    localparam logic [c_CW-1:0] c_STABLE_LAST = c_CW'(STABLE_CYCLES - 1);
    localparam logic [c_CW-1:0] c_HOLD_LAST   = c_CW'(HOLD_CYCLES - 1);
    localparam logic [c_CW-1:0] c_REPEAT_LAST = c_CW'(REPEAT_CYCLES - 1);
    localparam logic [c_PW-1:0] c_PULSE_LAST  = c_PW'(PULSE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARM  = 2'd1,
        S_HELD = 2'd2,
        S_REL  = 2'd3
    } state_t;

    logic            r_sync1;
    logic            r_btn_s;
    state_t          r_state;
    state_t          w_state_nxt;
    logic [c_CW-1:0] r_dcnt;
    logic [c_CW-1:0] w_dcnt_nxt;
    logic [c_CW-1:0] r_htmr;
    logic [c_CW-1:0] w_htmr_nxt;
    logic [c_CW-1:0] w_htmr_limit;
    logic            r_first_done;
    logic            w_first_nxt;
    logic            w_fire;
    logic            w_pressed_nxt;
    logic [c_PW-1:0] r_pcnt;

    // Two-flop synchroniser for the asynchronous button level
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_btn_s <= 1'b0;
        end else begin
            r_sync1 <= btn_in;
            r_btn_s <= r_sync1;
        end
    end

    // FSM state and debounce / repeat counters
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_dcnt       <= '0;
            r_htmr       <= '0;
            r_first_done <= 1'b0;
            pressed      <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_dcnt       <= w_dcnt_nxt;
            r_htmr       <= w_htmr_nxt;
            r_first_done <= w_first_nxt;
            pressed      <= w_pressed_nxt;
        end
    end

    // Next-state logic, counter updates and fire decision
    always_comb begin
        w_state_nxt  = r_state;
        w_dcnt_nxt   = r_dcnt;
        w_htmr_nxt   = r_htmr;
        w_first_nxt  = r_first_done;
        w_fire       = 1'b0;
        w_htmr_limit = r_first_done ? c_REPEAT_LAST : c_HOLD_LAST;

        case (r_state)
            S_IDLE: begin
                if (r_btn_s) begin
                    w_state_nxt = S_ARM;
                    w_dcnt_nxt  = '0;
                end
            end
            S_ARM: begin
                if (!r_btn_s) begin
                    // Bounce: level did not stay high long enough
                    w_state_nxt = S_IDLE;
                end else if (r_dcnt == c_STABLE_LAST) begin
                    w_state_nxt = S_HELD;
                    w_fire      = 1'b1;
                    w_htmr_nxt  = '0;
                    w_first_nxt = 1'b0;
                end else begin
                    w_dcnt_nxt = r_dcnt + 1'b1;
                end
            end
            S_HELD: begin
                // Release wins over a repeat tick due on the same edge
                if (!r_btn_s) begin
                    w_state_nxt = S_REL;
                    w_dcnt_nxt  = '0;
                end else if (repeat_en) begin
                    if (r_htmr == w_htmr_limit) begin
                        w_fire      = 1'b1;
                        w_first_nxt = 1'b1;
                        w_htmr_nxt  = '0;
                    end else begin
                        w_htmr_nxt = r_htmr + 1'b1;
                    end
                end
            end
            S_REL: begin
                // Short release glitch returns to HELD keeping the repeat timer
                if (r_btn_s) begin
                    w_state_nxt = S_HELD;
                end else if (r_dcnt == c_STABLE_LAST) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_dcnt_nxt = r_dcnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        w_pressed_nxt = (w_state_nxt == S_HELD) || (w_state_nxt == S_REL);
    end

    // Fixed-width tick pulse generator
    always_ff @(posedge clk) begin
        if (reset) begin
            tick_out <= 1'b0;
            r_pcnt   <= '0;
        end else if (w_fire) begin
            tick_out <= 1'b1;
            r_pcnt   <= c_PULSE_LAST;
        end else if (tick_out) begin
            if (r_pcnt == '0) begin
                tick_out <= 1'b0;
            end else begin
                r_pcnt <= r_pcnt - 1'b1;
            end
        end
    end

    // Running count of issued ticks, wraps modulo 256
    always_ff @(posedge clk) begin
        if (reset) begin
            tick_count <= 8'd0;
        end else if (w_fire) begin
            tick_count <= tick_count + 8'd1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_btn_tick_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_btn_tick_gen
// Brief    : Self-checking bench for btn_tick_gen with default parameters.
//            Table of press scenarios plus cycle-exact hand sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_btn_tick_gen;

    logic       clk;
    logic       reset;
    logic       btn_in;
    logic       repeat_en;
    logic       tick_out;
    logic       pressed;
    logic [7:0] tick_count;

    btn_tick_gen dut (
        .clk        (clk),
        .reset      (reset),
        .btn_in     (btn_in),
        .repeat_en  (repeat_en),
        .tick_out   (tick_out),
        .pressed    (pressed),
        .tick_count (tick_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         checks  = 0;
    int         errors  = 0;
    int         nticks  = 0;
    int         run     = 0;
    logic [7:0] exp_cnt = 8'd0;

    typedef struct {
        int   n;
        logic rep;
        int   ticks;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One clock edge; sample 1 time unit after it and track pulse widths
    task automatic step();
        @(posedge clk);
        #1;
        if (reset) begin
            run = 0;
        end else if (tick_out === 1'b1) begin
            run++;
            if (run == 1) nticks++;
        end else begin
            if (run > 0) chk("pulse_width", run, 2);
            run = 0;
        end
    endtask

    task automatic cyc(input logic b, input logic r, input logic et, input logic ep,
                       input string nm);
        btn_in    = b;
        repeat_en = r;
        step();
        chk({nm, " tick_out"}, {31'd0, tick_out}, {31'd0, et});
        chk({nm, " pressed"}, {31'd0, pressed}, {31'd0, ep});
    endtask

    task automatic press(input int n, input logic r);
        for (int i = 0; i < n; i++) begin
            btn_in    = 1'b1;
            repeat_en = r;
            step();
        end
        btn_in = 1'b0;
        for (int i = 0; i < 14; i++) step();
        repeat_en = 1'b0;
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, " tick_out"}, {31'd0, tick_out}, 0);
        chk({nm, " pressed"}, {31'd0, pressed}, 0);
        chk({nm, " tick_count"}, {24'd0, tick_count}, 0);
    endtask

    initial begin
        int t0;
        int bad;
        logic b;
        logic r;

        tbl[0] = '{n: 8,  rep: 1'b0, ticks: 0};
        tbl[1] = '{n: 9,  rep: 1'b0, ticks: 1};
        tbl[2] = '{n: 9,  rep: 1'b1, ticks: 1};
        tbl[3] = '{n: 40, rep: 1'b1, ticks: 1};
        tbl[4] = '{n: 41, rep: 1'b1, ticks: 2};
        tbl[5] = '{n: 56, rep: 1'b1, ticks: 3};
        tbl[6] = '{n: 57, rep: 1'b1, ticks: 4};
        tbl[7] = '{n: 60, rep: 1'b0, ticks: 1};

        // Reset with the button toggling
        reset     = 1'b1;
        btn_in    = 1'b0;
        repeat_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            btn_in = (i % 2 == 0);
            step();
            chk_reset_vals("reset");
        end
        reset  = 1'b0;
        btn_in = 1'b0;
        step();
        chk_reset_vals("post_reset");

        // Clean press, cycle exact
        for (int e = 0; e < 32; e++) begin
            cyc(e < 20, 1'b0, (e == 10 || e == 11), (e >= 10 && e <= 29), "clean");
        end
        exp_cnt = exp_cnt + 8'd1;
        chk("clean tick_count", {24'd0, tick_count}, {24'd0, exp_cnt});

        // Bounce rejection: 5 high / 5 low never reaches the stable count
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            btn_in = ((i / 5) % 2 == 0);
            step();
            if (tick_out !== 1'b0 || pressed !== 1'b0) bad++;
        end
        btn_in = 1'b0;
        for (int i = 0; i < 12; i++) step();
        chk("bounce glitches", bad, 0);
        chk("bounce tick_count", {24'd0, tick_count}, {24'd0, exp_cnt});

        // Table of press lengths / repeat modes
        for (int k = 0; k < 8; k++) begin
            t0 = nticks;
            press(tbl[k].n, tbl[k].rep);
            exp_cnt = exp_cnt + 8'(tbl[k].ticks);
            chk("vec tick_count", {24'd0, tick_count}, {24'd0, exp_cnt});
            chk("vec pulses", nticks - t0, tbl[k].ticks);
            chk("vec pressed", {31'd0, pressed}, 0);
        end

        // Release glitch in HELD: repeat schedule resumes from preserved timer
        for (int e = 0; e < 76; e++) begin
            b = !(e >= 20 && e <= 22) && (e <= 56);
            cyc(b, 1'b1, (e == 10 || e == 11 || e == 46 || e == 47 || e == 54 || e == 55),
                (e >= 10 && e <= 66), "glitch");
        end
        exp_cnt = exp_cnt + 8'd3;
        chk("glitch tick_count", {24'd0, tick_count}, {24'd0, exp_cnt});

        // repeat_en low freezes the hold timer without clearing it
        for (int e = 0; e < 71; e++) begin
            r = !(e >= 15 && e <= 24);
            cyc(e <= 53, r, (e == 10 || e == 11 || e == 52 || e == 53),
                (e >= 10 && e <= 63), "freeze");
        end
        exp_cnt = exp_cnt + 8'd2;
        chk("freeze tick_count", {24'd0, tick_count}, {24'd0, exp_cnt});

        // 256 presses from reset wrap the count back to zero
        reset = 1'b1;
        step();
        reset   = 1'b0;
        exp_cnt = 8'd0;
        t0      = nticks;
        for (int k = 0; k < 256; k++) press(9, 1'b0);
        chk("wrap tick_count", {24'd0, tick_count}, 0);
        chk("wrap pulses", nticks - t0, 256);

        // Reset on the edge right after firing kills the pulse
        for (int e = 0; e <= 10; e++) begin
            btn_in = 1'b1;
            step();
        end
        chk("midpulse fired", {31'd0, tick_out}, 1);
        chk("midpulse count", {24'd0, tick_count}, 1);
        reset = 1'b1;
        step();
        chk_reset_vals("midpulse_reset");
        reset  = 1'b0;
        btn_in = 1'b0;
        step();
        chk_reset_vals("midpulse_after");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/btn_tick_gen.md
# btn_tick_gen

Synchronous button conditioner that drives the clock input of the 4-bit ripple counter. It synchronises and debounces a raw push-button input and emits one clean, fixed-width `tick_out` pulse per accepted press. An optional auto-repeat mode emits further ticks while the button stays held. The downstream counter advances on each falling edge of `tick_out`; `tick_count` mirrors the number of ticks issued so the bench can cross-check the counter.

## Interface
Parameters:
- `STABLE_CYCLES`, default 8: consecutive synchronised-high (press) or synchronised-low (release) cycles required to accept a level; must be ≥ 2.
- `PULSE_CYCLES`, default 2: width of each `tick_out` pulse in clk cycles; must be ≥ 1.
- `HOLD_CYCLES`, default 32: delay from press acceptance to the first auto-repeat tick; must be ≥ `REPEAT_CYCLES`.
- `REPEAT_CYCLES`, default 8: spacing between later auto-repeat ticks; must be ≥ 2·`PULSE_CYCLES`.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-high; overrides everything else.
- `btn_in`  in  1: raw asynchronous button level, active-high.
- `repeat_en`  in  1: auto-repeat enable, sampled each cycle.
- `tick_out`  out  1: registered pulse feeding the counter clock.
- `pressed`  out  1: registered debounced button level.
- `tick_count`  out  8: total ticks issued, modulo 256.

## Operation
- Synchroniser: two flops, both reset to 0. `btn_s` is the second flop; only `btn_s` drives the FSM.
- FSM states and transitions:
  - IDLE: on `btn_s`=1, go to ARM and set `dcnt`=0.
  - ARM: on `btn_s`=0, return to IDLE (bounce rejected, no tick). Otherwise increment `dcnt`. At the edge where `dcnt`==`STABLE_CYCLES`-1 and `btn_s`=1, accept the press: go to HELD, fire a tick, clear `htmr`, clear `first_done`.
  - HELD: on `btn_s`=0, go to REL and set `dcnt`=0. Otherwise increment `htmr`, but only while `repeat_en`=1. When `htmr` reaches its limit, fire a tick, set `first_done`=1 and clear `htmr`. The limit is `HOLD_CYCLES`-1 when `first_done`=0 and `REPEAT_CYCLES`-1 when `first_done`=1.
  - REL: on `btn_s`=1, return to HELD with `htmr` and `first_done` preserved (no tick). Otherwise increment `dcnt`. At the edge where `dcnt`==`STABLE_CYCLES`-1, go to IDLE.
- `repeat_en`=0 in HELD freezes `htmr`. Deasserting `repeat_en` never clears the repeat timer.
- `pressed` = 1 in HELD and REL, 0 in IDLE and ARM.
- Fire: `tick_out` goes to 1 on the firing edge and stays high for exactly `PULSE_CYCLES` cycles, timed by a pulse counter. The parameter constraints guarantee that a new fire never coincides with an active pulse.
- `tick_count` increments on each firing edge and wraps from 255 to 0.
- Counter widths: `dcnt` and `htmr` are sized by `$clog2` of the largest parameter, and must never overflow.

## Timing
- Reset values: `tick_out`=0, `pressed`=0, `tick_count`=0, state=IDLE, synchroniser flops=0, all internal counters=0.
- Press latency: `btn_in` first sampled high at edge E and held there gives `btn_s`=1 after edge E+1, ARM after edge E+2, and the firing edge at E+2+`STABLE_CYCLES`. With defaults, `tick_out` is high after edges 10 and 11 and low after edge 12.
- Falling edge of `tick_out` is at firing edge + `PULSE_CYCLES`. This is the instant the downstream counter advances.
- Auto-repeat ticks fire at accept + `HOLD_CYCLES`, then every `REPEAT_CYCLES` while HELD with `repeat_en`=1.
- Release latency: `btn_s` low at edge R gives REL after R and IDLE after R+`STABLE_CYCLES`. A new press is accepted only from IDLE.
- Reset mid-pulse forces `tick_out` to 0 at the reset edge. The system ties the counter's asynchronous reset to the same `reset`, so the counter's reset dominates that falling edge.
- Simultaneous events: reset beats everything. In HELD, `btn_s`=0 beats a due repeat tick (no tick fires).

## Test plan
- Reset: assert `reset` for 3 cycles with `btn_in` toggling -> `tick_out`=0, `pressed`=0, `tick_count`=0 throughout and on the first cycle after release.
- Clean press (defaults, `repeat_en`=0): `btn_in`=1 from edge 0 for 20 cycles, then 0 -> one pulse, high after edges 10–11; `pressed` rises after edge 10; `tick_count`=1; IDLE reached 2+8 edges after release.
- Bounce reject: `btn_in` alternates 5 cycles high / 5 cycles low for 100 cycles -> no tick, `pressed` stays 0, `tick_count`=0.
- Auto-repeat: `repeat_en`=1, `btn_in` high edges 0–59 -> ticks fire at edges 10, 42, 50, 58, giving `tick_count`=4. Same stimulus with `repeat_en`=0 -> `tick_count`=1.
- Release glitch: in HELD, `btn_in` low for 3 cycles then high again -> `pressed` stays 1, no extra tick, repeat schedule resumes from the preserved `htmr`.
- Wrap and mid-pulse reset: 256 clean presses -> `tick_count`=0. Then press and assert `reset` on the edge after firing -> `tick_out`=0 and all outputs at reset values on the next cycle.
